// File: rtl/lpc_pkg.sv
// Shared types and constants for the LPC transaction decoder.
package lpc_pkg;

  typedef enum logic [3:0] {
    StIdle, StCyctype, StAddr, StWdata, StTar1, StSync, StRdata, StTar2, StSkip
  } lpc_state_e;

  localparam logic [1:0] CYC_IO   = 2'b00;
  localparam logic [1:0] CYC_MEM  = 2'b01;
  localparam logic [1:0] CYC_DMA  = 2'b10;
  localparam logic [1:0] CYC_RSVD = 2'b11;

  localparam logic [3:0] SYNC_READY = 4'b0000;
  localparam logic [3:0] SYNC_SWAIT = 4'b0101;
  localparam logic [3:0] SYNC_LWAIT = 4'b0110;
  localparam logic [3:0] SYNC_ERR   = 4'b1010;

`ifdef LPC_FWH_EN
  localparam logic [3:0] START_FWH_RD = 4'b1101;
  localparam logic [3:0] START_FWH_WR = 4'b1110;
`endif

  localparam logic [1:0] STS_OK       = 2'd0;
  localparam logic [1:0] STS_SYNC_ERR = 2'd1;
  localparam logic [1:0] STS_TIMEOUT  = 2'd2;
  localparam logic [1:0] STS_ABORT    = 2'd3;

  typedef struct packed {
    logic [3:0]  cyctype_dir;
    logic [31:0] addr;
    logic [7:0]  data;
    logic [1:0]  status;
  } lpc_rec_t;

  localparam int unsigned REC_W = $bits(lpc_rec_t);

endpackage

// File: rtl/lpc_rec_fifo.sv
// Synchronous show-ahead record FIFO; the head entry is always on o_data.
module lpc_rec_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 46
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A pop frees the slot in the same cycle, so a push into a full FIFO still lands.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/lpc_txn_decoder.sv
// Passive LPC cycle decoder producing status records into a FIFO.
// Define LPC_FWH_EN to also decode firmware-hub read/write cycles.
module lpc_txn_decoder
  import lpc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned MAX_SYNC_WAIT = 64,
  parameter int unsigned DROP_CNT_W    = 16
) (
  input  logic                  lpc_clock,
  input  logic                  reset,
  input  logic [3:0]            lpc_ad,
  input  logic                  lpc_frame,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_cyctype_dir,
  output logic [31:0]           out_addr,
  output logic [7:0]            out_data,
  output logic [1:0]            out_status,
  output logic [DROP_CNT_W-1:0] drop_count
);

  lpc_state_e             r_state, w_state_d;
  logic [3:0]             r_cnt, w_cnt_d;
  logic [9:0]             r_wait, w_wait_d;
  logic [3:0]             r_cyc, w_cyc_d;
  logic [31:0]            r_addr, w_addr_d;
  logic [7:0]             r_data, w_data_d;
  logic [DROP_CNT_W-1:0]  r_drop;

  logic                   w_push;
  lpc_rec_t               w_rec;
  lpc_rec_t               w_head;
  logic [REC_W-1:0]       w_fifo_data;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_start;
  logic [3:0]             w_last;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_wait_d  = r_wait;
    w_cyc_d   = r_cyc;
    w_addr_d  = r_addr;
    w_data_d  = r_data;
    w_push    = 1'b0;
    w_rec     = '{cyctype_dir: r_cyc, addr: r_addr, data: 8'h00, status: STS_OK};
    w_start   = !lpc_frame && (lpc_ad == 4'b0000);
`ifdef LPC_FWH_EN
    // FWH: IDSEL + 7 address nibbles shift in, MSIZE arrives as nibble index 8.
    w_last = (r_cyc[3:2] == CYC_IO) ? 4'd3 : (r_cyc[3:2] == CYC_MEM) ? 4'd7 : 4'd8;
`else
    w_last = (r_cyc[3:2] == CYC_IO) ? 4'd3 : 4'd7;
`endif

    if (!lpc_frame && r_state != StIdle && r_state != StSkip) begin
      if (r_state != StCyctype) begin
        w_push       = 1'b1;
        w_rec.status = STS_ABORT;
      end
      w_state_d = w_start ? StCyctype : StIdle;
    end else begin
      case (r_state)
        StIdle, StSkip: begin
          if (w_start) begin
            w_state_d = StCyctype;
`ifdef LPC_FWH_EN
          end else if (!lpc_frame && (lpc_ad == START_FWH_RD || lpc_ad == START_FWH_WR)) begin
            w_cyc_d   = {CYC_RSVD, lpc_ad == START_FWH_WR, 1'b1};
            w_addr_d  = '0;
            w_data_d  = '0;
            w_cnt_d   = '0;
            w_state_d = StAddr;
`endif
          end else if (!lpc_frame) begin
            w_state_d = StIdle;
          end
        end
        StCyctype: begin
          w_cyc_d  = lpc_ad;
          w_addr_d = '0;
          w_data_d = '0;
          w_cnt_d  = '0;
          case (lpc_ad[3:2])
            CYC_IO, CYC_MEM:  w_state_d = StAddr;
            CYC_DMA, CYC_RSVD: w_state_d = StSkip;
            default:           w_state_d = StSkip;
          endcase
        end
        StAddr: begin
          w_cnt_d = r_cnt + 4'd1;
          if (r_cnt < 4'd8) w_addr_d = {r_addr[27:0], lpc_ad};
          if (r_cnt == w_last) begin
            w_cnt_d   = '0;
            w_state_d = r_cyc[1] ? StWdata : StTar1;
`ifdef LPC_FWH_EN
            if (r_cyc[3:2] == CYC_RSVD && lpc_ad != 4'b0000) w_state_d = StSkip;
`endif
          end
        end
        StWdata: begin
          if (r_cnt == 4'd0) begin
            w_data_d[3:0] = lpc_ad;
            w_cnt_d       = 4'd1;
          end else begin
            w_data_d[7:4] = lpc_ad;
            w_cnt_d       = '0;
            w_state_d     = StTar1;
          end
        end
        StTar1: begin
          if (r_cnt == 4'd1) begin
            w_cnt_d   = '0;
            w_wait_d  = '0;
            w_state_d = StSync;
          end else begin
            w_cnt_d = 4'd1;
          end
        end
        StSync: begin
          case (lpc_ad)
            SYNC_READY: begin
              if (r_cyc[1]) begin
                w_push     = 1'b1;
                w_rec.data = r_data;
                w_state_d  = StTar2;
              end else begin
                w_state_d = StRdata;
              end
            end
            SYNC_ERR: begin
              w_push       = 1'b1;
              w_rec.status = STS_SYNC_ERR;
              w_state_d    = StTar2;
            end
            SYNC_SWAIT, SYNC_LWAIT: ;
            default: ;
          endcase
          if (lpc_ad != SYNC_READY && lpc_ad != SYNC_ERR) begin
            if (r_wait == 10'(MAX_SYNC_WAIT - 1)) begin
              w_push       = 1'b1;
              w_rec.status = STS_TIMEOUT;
              w_state_d    = StIdle;
            end else begin
              w_wait_d = r_wait + 10'd1;
            end
          end
        end
        StRdata: begin
          if (r_cnt == 4'd0) begin
            w_data_d[3:0] = lpc_ad;
            w_cnt_d       = 4'd1;
          end else begin
            w_data_d[7:4] = lpc_ad;
            w_push        = 1'b1;
            w_rec.data    = {lpc_ad, r_data[3:0]};
            w_cnt_d       = '0;
            w_state_d     = StTar2;
          end
        end
        StTar2: begin
          if (r_cnt == 4'd1) begin
            w_cnt_d   = '0;
            w_state_d = StIdle;
          end else begin
            w_cnt_d = 4'd1;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge lpc_clock or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_wait  <= '0;
      r_cyc   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_drop  <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_wait  <= w_wait_d;
      r_cyc   <= w_cyc_d;
      r_addr  <= w_addr_d;
      r_data  <= w_data_d;
      if (w_push && w_full && !w_pop && r_drop != '1) r_drop <= r_drop + 1'b1;
    end
  end

  assign w_pop = out_valid && out_ready;

  lpc_rec_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .i_clk   (lpc_clock),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_data  (w_rec),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head          = w_fifo_data;
  assign out_valid       = !w_empty;
  assign out_cyctype_dir = out_valid ? w_head.cyctype_dir : '0;
  assign out_addr        = out_valid ? w_head.addr : '0;
  assign out_data        = out_valid ? w_head.data : '0;
  assign out_status      = out_valid ? w_head.status : '0;
  assign drop_count      = r_drop;

endmodule

// File: tb/tb_lpc_txn_decoder.sv
// Scoreboard bench for lpc_txn_decoder with a 2-deep FIFO and a 4-clock SYNC timeout.
module tb_lpc_txn_decoder;

  logic        lpc_clock = 1'b0;
  logic        reset;
  logic [3:0]  lpc_ad;
  logic        lpc_frame;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_cyctype_dir;
  logic [31:0] out_addr;
  logic [7:0]  out_data;
  logic [1:0]  out_status;
  logic [15:0] drop_count;

  int n_checks = 0;
  int n_pass   = 0;
  logic [45:0] sb[$];

  lpc_txn_decoder #(
    .FIFO_DEPTH    (2),
    .MAX_SYNC_WAIT (4),
    .DROP_CNT_W    (16)
  ) dut (
    .lpc_clock       (lpc_clock),
    .reset           (reset),
    .lpc_ad          (lpc_ad),
    .lpc_frame       (lpc_frame),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_cyctype_dir (out_cyctype_dir),
    .out_addr        (out_addr),
    .out_data        (out_data),
    .out_status      (out_status),
    .drop_count      (drop_count)
  );

  always #5 lpc_clock = ~lpc_clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic sb_push(input logic [3:0] c, input logic [31:0] a, input logic [7:0] d,
                         input logic [1:0] s);
    sb.push_back({c, a, d, s});
  endtask

  // Monitor: compare every accepted head record against the scoreboard.
  always @(negedge lpc_clock) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_rec: got %h expected none",
                 {out_cyctype_dir, out_addr, out_data, out_status});
      end else begin
        chk("rec", {18'h0, out_cyctype_dir, out_addr, out_data, out_status}, {18'h0, sb.pop_front()});
      end
    end
  end

  task automatic drv(input logic f, input logic [3:0] a);
    lpc_frame = f;
    lpc_ad    = a;
    @(posedge lpc_clock);
    #1;
  endtask

  task automatic txn(input bit do_start, input logic [3:0] cyc, input logic [31:0] addr,
                     input int nib, input logic [7:0] data, input int nwait,
                     input logic [3:0] wcode, input logic [3:0] sync);
    if (do_start) drv(1'b0, 4'h0);
    drv(1'b1, cyc);
    for (int i = nib - 1; i >= 0; i--) drv(1'b1, addr[i*4 +: 4]);
    if (cyc[1]) begin
      drv(1'b1, data[3:0]);
      drv(1'b1, data[7:4]);
    end
    drv(1'b1, 4'hF);
    drv(1'b1, 4'hF);
    for (int i = 0; i < nwait; i++) drv(1'b1, wcode);
    drv(1'b1, sync);
    if (!cyc[1] && sync == 4'h0) begin
      drv(1'b1, data[3:0]);
      chk("rd_latency_lo", {63'h0, out_valid}, 64'h0);
      drv(1'b1, data[7:4]);
      chk("rd_latency_hi", {63'h0, out_valid}, 64'h1);
    end
    drv(1'b1, 4'hF);
    drv(1'b1, 4'hF);
    drv(1'b1, 4'hF);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge lpc_clock);
    #1;
    chk(name, 64'(sb.size()), 64'h0);
  endtask

  initial begin
    reset     = 1'b1;
    lpc_frame = 1'b1;
    lpc_ad    = 4'hF;
    out_ready = 1'b1;
    repeat (2) @(posedge lpc_clock);
    #1;
    chk("rst_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_cyc", {60'h0, out_cyctype_dir}, 64'h0);
    chk("rst_addr", {32'h0, out_addr}, 64'h0);
    chk("rst_data", {56'h0, out_data}, 64'h0);
    chk("rst_status", {62'h0, out_status}, 64'h0);
    chk("rst_drop", {48'h0, drop_count}, 64'h0);
    reset = 1'b0;
    drv(1'b1, 4'hF);

    // I/O write with two short waits
    sb_push(4'h2, 32'h0000_0080, 8'h5A, 2'd0);
    txn(1, 4'h2, 32'h0080, 4, 8'h5A, 2, 4'h5, 4'h0);
    // Memory read, data nibbles 3 then C
    sb_push(4'h4, 32'hFFFF_FFF0, 8'hC3, 2'd0);
    txn(1, 4'h4, 32'hFFFF_FFF0, 8, 8'hC3, 0, 4'h5, 4'h0);
    // I/O read with SYNC error
    sb_push(4'h0, 32'h0000_03F8, 8'h00, 2'd1);
    txn(1, 4'h0, 32'h03F8, 4, 8'h00, 0, 4'h5, 4'hA);
    // I/O read timing out on long wait; trailing nibbles land in IDLE
    sb_push(4'h0, 32'h0000_0060, 8'h00, 2'd2);
    txn(1, 4'h0, 32'h0060, 4, 8'h00, 4, 4'h6, 4'hF);
    drain("drain_basic");

    // DMA cycle is skipped silently
    drv(1'b0, 4'h0);
    drv(1'b1, 4'h8);
    for (int i = 0; i < 5; i++) drv(1'b1, 4'(i + 1));
    chk("dma_no_rec", {63'h0, out_valid}, 64'h0);

    // Abort in the 3rd address nibble with back-to-back restart
    drv(1'b0, 4'h0);
    drv(1'b1, 4'h0);
    drv(1'b1, 4'h1);
    drv(1'b1, 4'h2);
    sb_push(4'h0, 32'h0000_0012, 8'h00, 2'd3);
    sb_push(4'h2, 32'h0000_1234, 8'hA5, 2'd0);
    drv(1'b0, 4'h0);
    txn(0, 4'h2, 32'h1234, 4, 8'hA5, 0, 4'h5, 4'h0);
    drain("drain_abort");

    // Reset mid-ADDR discards the held record and the partial cycle
    out_ready = 1'b0;
    txn(1, 4'h2, 32'h0070, 4, 8'h77, 0, 4'h5, 4'h0);
    chk("held_valid", {63'h0, out_valid}, 64'h1);
    chk("held_data", {56'h0, out_data}, 64'h77);
    drv(1'b0, 4'h0);
    drv(1'b1, 4'h2);
    drv(1'b1, 4'h0);
    drv(1'b1, 4'h1);
    reset = 1'b1;
    #1;
    chk("rst_mid_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_mid_data", {56'h0, out_data}, 64'h0);
    @(posedge lpc_clock);
    #1;
    reset     = 1'b0;
    lpc_frame = 1'b1;
    lpc_ad    = 4'hF;
    out_ready = 1'b1;
    drv(1'b1, 4'hF);
    sb_push(4'h2, 32'h0000_002E, 8'h11, 2'd0);
    txn(1, 4'h2, 32'h002E, 4, 8'h11, 0, 4'h5, 4'h0);
    drain("drain_after_rst");

    // Overflow: four writes into a 2-deep FIFO with the consumer stalled
    out_ready = 1'b0;
    sb_push(4'h2, 32'h0000_0010, 8'h01, 2'd0);
    sb_push(4'h2, 32'h0000_0011, 8'h02, 2'd0);
    for (int i = 0; i < 4; i++) txn(1, 4'h2, 32'(16 + i), 4, 8'(i + 1), 0, 4'h5, 4'h0);
    chk("drop_count", {48'h0, drop_count}, 64'h2);
    chk("full_head_addr", {32'h0, out_addr}, 64'h10);
    repeat (3) @(posedge lpc_clock);
    #1;
    chk("stall_addr", {32'h0, out_addr}, 64'h10);
    chk("stall_data", {56'h0, out_data}, 64'h01);
    out_ready = 1'b1;
    drain("drain_overflow");
    repeat (2) @(posedge lpc_clock);
    #1;
    chk("final_valid", {63'h0, out_valid}, 64'h0);
    chk("final_drop", {48'h0, drop_count}, 64'h2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
